hash_stub_responder: RTL
========================

Name: hash_stub_responder

Overview:
- Responder end of the SHAKE128 stub handshake; answers the hash controller's shake128_full_in / shake128_done pair.
- On a request it reads IN_BYTES seed bytes from ram_a and streams them out on a byte interface to the external software model.
- It writes the returned OUT_BYTES into ram_b, then raises done under a 4-phase handshake.
- Sits between the hash control FSM, the two byte RAMs and the testbench/host bridge.

Parameters:
- IN_BYTES, 32, seed bytes read from ram_a per request (1..255).
- OUT_BYTES, 168, squeezed bytes written to ram_b per request (1..255; 168 = SHAKE128 rate).
- ADDR_W, 8, RAM address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- full_in  in  1  request level from controller (its shake128_full_in).
- done  out  1  completion level (controller's shake128_done).
- abort  out  1  one-cycle pulse: request withdrawn mid-operation.
- busy  out  1  high in any state other than IDLE.
- ram_a_addr  out  ADDR_W  ram_a read address; ram_a_rdata valid 1 cycle later.
- ram_a_rdata  in  8  ram_a read data.
- tx_data  out  8  seed byte to host.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  marks byte IN_BYTES-1.
- tx_ready  in  1  host accepts the byte.
- rx_data  in  8  squeezed byte from host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  responder accepts the byte.
- ram_b_addr  out  ADDR_W  ram_b write address.
- ram_b_wdata  out  8  ram_b write data.
- ram_b_we  out  1  ram_b write strobe.

Behaviour:
- Reset: all outputs 0, byte counter 0, state IDLE. Reset mid-operation abandons the transfer silently: no abort pulse, no done.
- States: IDLE, FETCH, HOLD, TX, RX, WRLAST, DONE.
- IDLE:
  - full_in=1 -> FETCH, counter cleared.
  - full_in=0 -> stay.
- FETCH: drive ram_a_addr=counter -> HOLD.
- HOLD: capture ram_a_rdata into tx_data, set tx_valid=1, set tx_last=(counter==IN_BYTES-1) -> TX.
- TX:
  - Hold tx_data, tx_valid and tx_last stable until tx_ready.
  - On tx_valid&tx_ready: drop tx_valid.
    - Not last: counter+1 -> FETCH.
    - Last: counter cleared -> RX.
  - Peak throughput is one byte per 3 cycles. Minimum request-to-first-tx_valid latency is 2 cycles after full_in is sampled high.
- RX:
  - rx_ready=1.
  - On rx_valid&rx_ready: next cycle ram_b_we=1, ram_b_addr=counter, ram_b_wdata=rx_data. These are registered, 1-cycle write latency. Counter then increments.
  - On the handshake for byte OUT_BYTES-1: rx_ready drops the next cycle -> WRLAST.
  - Bytes are accepted back-to-back, one per cycle.
- WRLAST: final ram_b_we cycle completes -> DONE.
- DONE:
  - done=1, held while full_in=1.
  - When full_in=0: done=0 -> IDLE.
  - The controller must see done before clearing the request.
- Abort:
  - Trigger: full_in falls in FETCH, HOLD, TX or RX.
  - Effect: tx_valid=0, rx_ready=0, abort=1 for one cycle -> IDLE.
  - A ram_b write already registered still completes.
  - abort is never asserted for a drop seen in DONE or IDLE.
- Counter:
  - 8-bit, compared only against IN_BYTES-1 / OUT_BYTES-1, so it never wraps.
  - ram_a_addr and ram_b_addr are the zero-extended counter.
- Simultaneous events: full_in re-asserted in the same cycle done clears is ignored; a new request is taken only from IDLE. rx_valid in any state other than RX is ignored.
- ram_b_we is never high in the same cycle as tx_valid.

Decomposition:
- Shared package: state encoding; defaults SHAKE128_RATE_BYTES=168 and SEED_BYTES=32, also used by the hash control FSM and the benches.
- One natural sub-module: hash_stub_byte_ctr. It is the 8-bit counter with clear, increment and is_last compare against a terminal value, instantiated once and reused for the TX and RX phases.

Test Plan:
1. Nominal: ram_a[i]=i for i=0..31; full_in=1; tx_ready always 1; host returns 8'hA0+i (mod 256) for 168 bytes back-to-back.
   -> 32 tx bytes 00..1F, tx_last only on 1F; ram_b[0..167] match; done=1 after the last write; full_in=0 -> done=0 the next cycle, busy=0.
2. TX backpressure: tx_ready low 5 cycles on byte 7.
   -> tx_data=07 and tx_valid held stable all 5 cycles; no duplicate or skipped byte.
3. RX gaps: rx_valid toggles 1,0,0,1 pattern.
   -> ram_b_we pulses exactly 168 times, addresses 0..167 contiguous; done only after the 168th write.
4. Abort: drop full_in during TX at byte 10.
   -> abort pulses once, tx_valid=0 next cycle, state IDLE. A following request restarts at ram_a_addr=0.
5. Sync reset during RX at byte 50.
   -> all outputs 0 next cycle, no abort, no done. A later request completes cleanly with addresses starting at 0.
6. Hold-off: full_in kept high 20 cycles after done.
   -> done stays 1, no second transfer (tx_valid stays 0) until full_in is low for one cycle and re-asserted.

Source files
------------

// File: rtl/hash_stub_responder_pkg.sv
// Shared definitions for the SHAKE128 stub handshake: state encoding and default byte counts.
// Also imported by the hash control FSM and the benches.
package hash_stub_responder_pkg;

    localparam int SHAKE128_RATE_BYTES = 168;
    localparam int SEED_BYTES          = 32;
    localparam int CTR_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_TX,
        ST_RX,
        ST_WRLAST,
        ST_DONE
    } state_e;

    // Index of the final byte of an n-byte phase.
    function automatic logic [CTR_W-1:0] last_index(input int n_bytes);
        return CTR_W'(n_bytes - 1);
    endfunction

    // States in which the controller withdrawing its request cancels the transfer.
    function automatic logic abortable(input state_e s);
        return (s == ST_FETCH) || (s == ST_HOLD) || (s == ST_TX) || (s == ST_RX);
    endfunction

endpackage

// File: rtl/hash_stub_byte_ctr.sv
// Byte counter shared by the TX and RX phases: clear, increment and a compare against
// the caller's terminal index.
module hash_stub_byte_ctr
    import hash_stub_responder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [CTR_W-1:0] terminal,
    output logic [CTR_W-1:0] count,
    output logic             is_last
);

    logic [CTR_W-1:0] count_q;
    logic [CTR_W-1:0] count_d;

    always_comb begin
        // NOTE: assigning the default first means every path drives count_d, so no latch.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking <= so every flop updates from values sampled before the edge.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign is_last = (count_q == terminal);

endmodule

// File: rtl/hash_stub_responder.sv
// Responder end of the SHAKE128 stub handshake: streams seed bytes from ram_a to the host,
// writes the squeezed bytes it returns into ram_b, then holds done until the request drops.
module hash_stub_responder
    import hash_stub_responder_pkg::*;
#(
    parameter int IN_BYTES  = SEED_BYTES,
    parameter int OUT_BYTES = SHAKE128_RATE_BYTES,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              full_in,
    output logic              done,
    output logic              abort,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_a_addr,
    input  logic [7:0]        ram_a_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              tx_last,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] ram_b_addr,
    output logic [7:0]        ram_b_wdata,
    output logic              ram_b_we
);

    state_e            state_q,       state_d;
    logic [7:0]        tx_data_q,     tx_data_d;
    logic              tx_valid_q,    tx_valid_d;
    logic              tx_last_q,     tx_last_d;
    logic              abort_q,       abort_d;
    logic              ram_b_we_q,    ram_b_we_d;
    logic [ADDR_W-1:0] ram_b_addr_q,  ram_b_addr_d;
    logic [7:0]        ram_b_wdata_q, ram_b_wdata_d;

    logic              ctr_clr;
    logic              ctr_inc;
    logic [CTR_W-1:0]  ctr_terminal;
    logic [CTR_W-1:0]  ctr_count;
    logic              ctr_is_last;

    // One counter serves both phases; only its terminal index changes.
    assign ctr_terminal = (state_q == ST_RX) ? last_index(OUT_BYTES) : last_index(IN_BYTES);

    hash_stub_byte_ctr u_byte_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (ctr_clr),
        .inc      (ctr_inc),
        .terminal (ctr_terminal),
        .count    (ctr_count),
        .is_last  (ctr_is_last)
    );

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        tx_last_d     = tx_last_q;
        abort_d       = 1'b0;
        ram_b_we_d    = 1'b0;
        ram_b_addr_d  = ram_b_addr_q;
        ram_b_wdata_d = ram_b_wdata_q;
        ctr_clr       = 1'b0;
        ctr_inc       = 1'b0;

        if (abortable(state_q) && !full_in) begin
            // A withdrawn request wins over any handshake landing on the same edge.
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            abort_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (full_in) begin
                        state_d = ST_FETCH;
                        ctr_clr = 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    tx_data_d  = ram_a_rdata;
                    tx_valid_d = 1'b1;
                    tx_last_d  = ctr_is_last;
                    state_d    = ST_TX;
                end
                ST_TX: begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        if (ctr_is_last) begin
                            ctr_clr = 1'b1;
                            state_d = ST_RX;
                        end else begin
                            ctr_inc = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_RX: begin
                    if (rx_valid) begin
                        ram_b_we_d    = 1'b1;
                        ram_b_addr_d  = ADDR_W'(ctr_count);
                        ram_b_wdata_d = rx_data;
                        ctr_inc       = 1'b1;
                        if (ctr_is_last) begin
                            state_d = ST_WRLAST;
                        end
                    end
                end
                ST_WRLAST: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    // A new request is only taken from IDLE, so a re-raise here is ignored.
                    if (!full_in) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_last_q     <= 1'b0;
            abort_q       <= 1'b0;
            ram_b_we_q    <= 1'b0;
            ram_b_addr_q  <= '0;
            ram_b_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_last_q     <= tx_last_d;
            abort_q       <= abort_d;
            ram_b_we_q    <= ram_b_we_d;
            ram_b_addr_q  <= ram_b_addr_d;
            ram_b_wdata_q <= ram_b_wdata_d;
        end
    end

    assign done        = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign rx_ready    = (state_q == ST_RX);
    assign abort       = abort_q;
    assign ram_a_addr  = ADDR_W'(ctr_count);
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign tx_last     = tx_last_q;
    assign ram_b_we    = ram_b_we_q;
    assign ram_b_addr  = ram_b_addr_q;
    assign ram_b_wdata = ram_b_wdata_q;

endmodule
